uart_rx_fsm: RTL and testbench
==============================

Name: uart_rx_fsm

Overview:
Sequencing controller for the UART receiver. It owns the per-bit edge counter and the bit counter, and walks each frame through start, data, optional parity and stop. It pulses the enables consumed by the data sampler, deserializer, start/parity/stop checkers, then qualifies the frame with a one-cycle data_valid pulse. It sits in the RX clock domain between the serial input and the RX datapath sub-blocks.

Parameters:
Data_width, 8, number of data bits per frame (1..15).
Prescale_w, 6, width of prescale and edge_cnt.

Ports:
CLK  input  1  RX oversampling clock.
RST  input  1  asynchronous, active-low reset.
RX_IN  input  1  serial line, idle high.
PAR_EN  input  1  1 = frame carries a parity bit.
prescale  input  Prescale_w  clocks per bit; legal values 8, 16, 32.
strt_glitch  input  1  start checker result, valid at last edge of the start bit.
par_err  input  1  parity checker result, valid at last edge of the parity bit.
stp_err  input  1  stop checker result, valid at last edge of the stop bit.
edge_cnt  output  Prescale_w  edge index within the current bit, 0..prescale-1.
bit_cnt  output  4  data-bit index, 0..Data_width-1.
dat_samp_en  output  1  sampler enable.
deser_en  output  1  one-cycle shift strobe to the deserializer.
strt_chk_en  output  1  start-check enable.
par_chk_en  output  1  parity-check enable.
stp_chk_en  output  1  stop-check enable.
data_valid  output  1  one-cycle pulse for a good frame.
par_err_flg  output  1  frame-level parity error, held until the next frame starts.
stp_err_flg  output  1  frame-level framing error, held until the next frame starts.

Behaviour:
- Reset (async assert, RST=0): state IDLE. All outputs are 0: counters, enables, data_valid and both flags.
- States:
  - IDLE, START, DATA, PARITY, STOP, CHECK.
  - "Last edge" means edge_cnt == pscl-1.
- pscl is a register. prescale is latched into pscl on the IDLE->START transition. A prescale change mid-frame has no effect until the next frame.
- edge_cnt:
  - Is 0 in IDLE.
  - Increments every cycle in START/DATA/PARITY/STOP.
  - Wraps to 0 after the last edge.
- IDLE:
  - RX_IN=0 sampled at a clock edge moves to START with edge_cnt=1. The detect cycle counts as edge 0.
  - Both flags clear on this transition.
- START:
  - strt_chk_en=1 and dat_samp_en=1.
  - At the last edge: strt_glitch=1 goes to IDLE (no flags, no data_valid); otherwise goes to DATA with bit_cnt=0.
- DATA:
  - dat_samp_en=1.
  - deser_en pulses for exactly one cycle at each last edge.
  - At the last edge with bit_cnt==Data_width-1: go to PARITY if PAR_EN=1, else STOP.
  - Otherwise bit_cnt increments at the last edge.
- PARITY:
  - par_chk_en=1 and dat_samp_en=1.
  - At the last edge, par_err is captured into par_err_flg and the FSM goes to STOP.
- STOP:
  - stp_chk_en=1 and dat_samp_en=1.
  - At the last edge, stp_err is captured into stp_err_flg and the FSM goes to CHECK.
- CHECK (exactly one cycle):
  - data_valid=1 iff both flags are 0.
  - Next state is START (edge_cnt=1) if RX_IN=0, else IDLE. Back-to-back frames lose no cycle.
  - Flags clear on entry to START from CHECK as well.
- PAR_EN is sampled only at the DATA->next decision.
- Enables are combinational from state/edge_cnt and are glitch-free relative to CLK.
- data_valid and the flags are registered outputs.
- bit_cnt holds its value outside DATA and resets to 0 on entry to DATA.
- Frame length in cycles: (2 + Data_width + PAR_EN) * pscl, plus 1 for CHECK.

Decomposition:
- Shared package uart_rx_pkg holds:
  - the state encoding (3-bit enumerated constants IDLE..CHECK);
  - legal prescale constants 8/16/32.
- One sub-module, uart_rx_edge_bit_cnt, holds edge_cnt/bit_cnt with inputs cnt_en, bit_inc and clr. The FSM drives it.

Test Plan:
1. Reset asserted mid-DATA (bit_cnt=3) -> outputs go to 0 immediately, without waiting for a clock edge; state IDLE; a following clean frame decodes normally.
2. prescale=8, PAR_EN=1, frame 0xA5 with correct even parity and stop=1, strt_glitch/par_err/stp_err held 0 -> exactly 8 deser_en pulses; data_valid high one cycle, 89 cycles after start detect; flags 0.
3. prescale=16, PAR_EN=0, 0x3C -> no par_chk_en cycles; STOP follows DATA; data_valid at cycle 161; par_err_flg 0.
4. Start glitch: RX_IN low 2 cycles, strt_glitch=1 at edge 7 (prescale=8) -> return to IDLE at cycle 8; no deser_en, no data_valid, flags unchanged.
5. par_err=1 at parity last edge, then stp_err=1 -> par_err_flg=1 and stp_err_flg=1 after CHECK; data_valid stays 0; both flags clear on the next start detect.
6. Two back-to-back frames with RX_IN=0 during CHECK, plus prescale changed 8->32 mid-frame 1 -> frame 1 finishes at 8 clocks/bit; frame 2 starts with no IDLE cycle and runs at 32 clocks/bit; two data_valid pulses.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared state encoding and prescale constants for the UART receiver
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    CHECK  = 3'd5
  } rx_state_e;

  localparam int unsigned PRESCALE_8  = 8;
  localparam int unsigned PRESCALE_16 = 16;
  localparam int unsigned PRESCALE_32 = 32;

  // True for the oversampling ratios the receiver is built for.
  function automatic logic legal_prescale(input int unsigned p);
    return (p == PRESCALE_8) || (p == PRESCALE_16) || (p == PRESCALE_32);
  endfunction

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// rtl/uart_rx_edge_bit_cnt.sv - per-bit edge counter and data-bit counter driven by the RX FSM
module uart_rx_edge_bit_cnt #(
  parameter int Prescale_w = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  clr,
  input  logic                  cnt_en,
  input  logic                  bit_clr,
  input  logic                  bit_inc,
  input  logic [Prescale_w-1:0] pscl,
  output logic [Prescale_w-1:0] edge_cnt,
  output logic [3:0]            bit_cnt,
  output logic                  last_edge
);

  assign last_edge = (edge_cnt == (pscl - Prescale_w'(1)));

  // Edge counter wraps after the last edge of a bit; bit counter steps once per data bit.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      if (clr) begin
        edge_cnt <= '0;
      end else if (cnt_en) begin
        edge_cnt <= last_edge ? '0 : edge_cnt + Prescale_w'(1);
      end
      if (bit_clr) begin
        bit_cnt <= '0;
      end else if (bit_inc) begin
        bit_cnt <= bit_cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/uart_rx_fsm.sv
// rtl/uart_rx_fsm.sv - UART receive sequencer: frame walk, datapath enables and frame qualification
module uart_rx_fsm
  import uart_rx_pkg::*;
#(
  parameter int Data_width = 8,
  parameter int Prescale_w = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic [Prescale_w-1:0] prescale,
  input  logic                  strt_glitch,
  input  logic                  par_err,
  input  logic                  stp_err,
  output logic [Prescale_w-1:0] edge_cnt,
  output logic [3:0]            bit_cnt,
  output logic                  dat_samp_en,
  output logic                  deser_en,
  output logic                  strt_chk_en,
  output logic                  par_chk_en,
  output logic                  stp_chk_en,
  output logic                  data_valid,
  output logic                  par_err_flg,
  output logic                  stp_err_flg
);

  rx_state_e             state;
  logic [Prescale_w-1:0] pscl;
  logic                  last_edge;
  logic                  waiting;
  logic                  start_det;
  logic                  last_bit;
  logic                  cnt_en;
  logic                  cnt_clr;
  logic                  bit_clr;
  logic                  bit_inc;

  // IDLE and CHECK both watch the line for a start bit; CHECK lets frames run back to back.
  assign waiting   = (state == IDLE) || (state == CHECK);
  assign start_det = waiting && !RX_IN;
  assign last_bit  = (bit_cnt == 4'(Data_width - 1));

  // The detect cycle is edge 0 of the start bit, so the counter already advances on it.
  assign cnt_en  = start_det || (state inside {START, DATA, PARITY, STOP});
  assign cnt_clr = waiting && RX_IN;
  assign bit_clr = (state == START) && last_edge && !strt_glitch;
  assign bit_inc = (state == DATA) && last_edge && !last_bit;

  assign dat_samp_en = state inside {START, DATA, PARITY, STOP};
  assign strt_chk_en = (state == START);
  assign par_chk_en  = (state == PARITY);
  assign stp_chk_en  = (state == STOP);
  assign deser_en    = (state == DATA) && last_edge;

  uart_rx_edge_bit_cnt #(
    .Prescale_w (Prescale_w)
  ) u_cnt (
    .CLK       (CLK),
    .RST       (RST),
    .clr       (cnt_clr),
    .cnt_en    (cnt_en),
    .bit_clr   (bit_clr),
    .bit_inc   (bit_inc),
    .pscl      (pscl),
    .edge_cnt  (edge_cnt),
    .bit_cnt   (bit_cnt),
    .last_edge (last_edge)
  );

  // Frame sequencing; prescale is frozen per frame and errors are latched into sticky flags.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= IDLE;
      pscl        <= '0;
      data_valid  <= 1'b0;
      par_err_flg <= 1'b0;
      stp_err_flg <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      case (state)
        IDLE, CHECK: begin
          if (!RX_IN) begin
            state       <= START;
            pscl        <= legal_prescale(32'(prescale)) ? prescale : Prescale_w'(PRESCALE_8);
            par_err_flg <= 1'b0;
            stp_err_flg <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end
        START: begin
          if (last_edge) begin
            state <= strt_glitch ? IDLE : DATA;
          end
        end
        DATA: begin
          if (last_edge && last_bit) begin
            state <= PAR_EN ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (last_edge) begin
            par_err_flg <= par_err;
            state       <= STOP;
          end
        end
        STOP: begin
          if (last_edge) begin
            stp_err_flg <= stp_err;
            data_valid  <= !stp_err && !par_err_flg;
            state       <= CHECK;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// tb/tb_uart_rx_fsm.sv - scoreboard bench for the UART receive sequencer
module tb_uart_rx_fsm;

  localparam int DW = 8;
  localparam int PW = 6;

  logic          CLK = 1'b0;
  logic          RST;
  logic          RX_IN;
  logic          PAR_EN;
  logic [PW-1:0] prescale;
  logic          strt_glitch;
  logic          par_err;
  logic          stp_err;
  logic [PW-1:0] edge_cnt;
  logic [3:0]    bit_cnt;
  logic          dat_samp_en;
  logic          deser_en;
  logic          strt_chk_en;
  logic          par_chk_en;
  logic          stp_chk_en;
  logic          data_valid;
  logic          par_err_flg;
  logic          stp_err_flg;

  typedef struct {
    int   kind;
    logic dv;
    logic pf;
    logic sf;
    int   lat;
    int   nd;
    int   np;
    int   gap;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  int   s_cyc  = 0;
  int   end_cyc = 0;
  int   gap    = 0;
  int   nd     = 0;
  int   np     = 0;
  logic prev_strt = 1'b0;
  logic prev_stp  = 1'b0;

  uart_rx_fsm #(.Data_width(DW), .Prescale_w(PW)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .RX_IN       (RX_IN),
    .PAR_EN      (PAR_EN),
    .prescale    (prescale),
    .strt_glitch (strt_glitch),
    .par_err     (par_err),
    .stp_err     (stp_err),
    .edge_cnt    (edge_cnt),
    .bit_cnt     (bit_cnt),
    .dat_samp_en (dat_samp_en),
    .deser_en    (deser_en),
    .strt_chk_en (strt_chk_en),
    .par_chk_en  (par_chk_en),
    .stp_chk_en  (stp_chk_en),
    .data_valid  (data_valid),
    .par_err_flg (par_err_flg),
    .stp_err_flg (stp_err_flg)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_edge_cnt"}, int'(edge_cnt), 0);
    chk({tag, "_bit_cnt"}, int'(bit_cnt), 0);
    chk({tag, "_enables"}, int'({dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en}), 0);
    chk({tag, "_data_valid"}, int'(data_valid), 0);
    chk({tag, "_flags"}, int'({par_err_flg, stp_err_flg}), 0);
  endtask

  task automatic idle(input int n);
    RX_IN = 1'b1; strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
    repeat (n) @(negedge CLK);
  endtask

  // Called at a negedge; returns at the negedge that opens the CHECK cycle.
  task automatic send_frame(input logic [7:0] d, input logic pe, input int ps, input int ps_after,
                            input logic perr, input logic serr, input logic exp_dv,
                            input logic exp_pf, input logic exp_sf, input int exp_lat, input int exp_gap);
    exp_t e;
    int   nbits;
    e.kind = 0; e.dv = exp_dv; e.pf = exp_pf; e.sf = exp_sf;
    e.lat = exp_lat; e.nd = DW; e.np = pe ? ps : 0; e.gap = exp_gap;
    q.push_back(e);
    nbits = 2 + DW + (pe ? 1 : 0);
    PAR_EN = pe;
    prescale = PW'(ps);
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < ps; c++) begin
        if (b == 1 && c == 0) prescale = PW'(ps_after);
        if (b == 0) RX_IN = 1'b0;
        else if (b <= DW) RX_IN = d[b-1];
        else if (pe && b == DW + 1) RX_IN = ^d;
        else RX_IN = 1'b1;
        par_err = (pe && b == DW + 1) ? perr : 1'b0;
        stp_err = (b == nbits - 1) ? serr : 1'b0;
        strt_glitch = 1'b0;
        @(negedge CLK);
      end
    end
  endtask

  task automatic send_glitch();
    exp_t e;
    e.kind = 1; e.dv = 1'b0; e.pf = 1'b0; e.sf = 1'b0;
    e.lat = 8; e.nd = 0; e.np = 0; e.gap = -1;
    q.push_back(e);
    prescale = PW'(8);
    for (int i = 0; i < 8; i++) begin
      RX_IN = (i < 2) ? 1'b0 : 1'b1;
      strt_glitch = (i == 7);
      @(negedge CLK);
    end
    strt_glitch = 1'b0;
  endtask

  // Monitor: tracks each frame from start detect and checks it against the scoreboard when it ends.
  always @(negedge CLK) begin : mon
    exp_t e;
    logic end_evt;
    logic glitch_evt;
    cyc++;
    if (!RST) begin
      prev_strt = 1'b0;
      prev_stp  = 1'b0;
    end else begin
      if (strt_chk_en && edge_cnt == PW'(1) && !prev_strt) begin
        chk("flags_clear_on_start", int'({par_err_flg, stp_err_flg}), 0);
        s_cyc = cyc;
        gap = cyc - end_cyc;
        nd = 0;
        np = 0;
      end
      if (deser_en) begin
        chk("bit_cnt_at_shift", int'(bit_cnt), nd);
        nd++;
      end
      if (par_chk_en) np++;
      end_evt    = prev_stp && !stp_chk_en;
      glitch_evt = prev_strt && !strt_chk_en && !dat_samp_en;
      if (end_evt || glitch_evt) begin
        end_cyc = cyc;
        if (q.size() == 0) begin
          chk("unexpected_frame_end", 1, 0);
        end else begin
          e = q.pop_front();
          chk("event_kind", glitch_evt ? 1 : 0, e.kind);
          chk("data_valid", int'(data_valid), int'(e.dv));
          chk("par_err_flg", int'(par_err_flg), int'(e.pf));
          chk("stp_err_flg", int'(stp_err_flg), int'(e.sf));
          chk("event_cycle", cyc - s_cyc + 1, e.lat);
          chk("deser_pulses", nd, e.nd);
          chk("par_chk_cycles", np, e.np);
          if (e.gap >= 0) chk("b2b_gap", gap, e.gap);
          if (e.kind == 0) chk("bit_cnt_hold", int'(bit_cnt), DW - 1);
          else chk("edge_cnt_idle", int'(edge_cnt), 0);
        end
      end else if (data_valid) begin
        chk("stray_data_valid", 1, 0);
      end
      prev_strt = strt_chk_en;
      prev_stp  = stp_chk_en;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic found;
    RST = 1'b0; RX_IN = 1'b1; PAR_EN = 1'b0; prescale = PW'(8);
    strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
    repeat (3) @(negedge CLK);
    chk_all_zero("reset");
    RST = 1'b1;
    idle(4);

    // prescale 8, parity, 0xA5 clean: CHECK is cycle 88, 89-cycle frame
    send_frame(8'hA5, 1'b1, 8, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 88, -1);
    idle(5);
    // prescale 16, no parity, 0x3C: 160 bit cycles then CHECK
    send_frame(8'h3C, 1'b0, 16, 16, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 160, -1);
    idle(5);
    // start glitch decided at edge 7, IDLE on cycle 8
    send_glitch();
    idle(5);
    // parity and stop errors: both flags set, no data_valid
    send_frame(8'h0F, 1'b1, 8, 8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 88, -1);
    idle(4);
    chk("par_flg_held", int'(par_err_flg), 1);
    chk("stp_flg_held", int'(stp_err_flg), 1);
    // stop error only, no parity: flags from the previous frame cleared at start
    send_frame(8'h33, 1'b0, 8, 8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 80, -1);
    idle(3);

    // reset mid-DATA at bit_cnt 3, asserted between clock edges
    PAR_EN = 1'b0; prescale = PW'(8); RX_IN = 1'b0;
    @(negedge CLK);
    RX_IN = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (dat_samp_en && !strt_chk_en && !par_chk_en && !stp_chk_en && bit_cnt == 4'd3) found = 1'b1;
      else @(negedge CLK);
    end
    chk("mid_data_reached", int'(found), 1);
    #2 RST = 1'b0;
    #1 chk_all_zero("async_reset");
    @(negedge CLK);
    RST = 1'b1;
    idle(3);
    send_frame(8'h5A, 1'b0, 8, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 80, -1);
    idle(3);

    // back-to-back: prescale moves 8->32 during frame 1, frame 2 starts in CHECK
    send_frame(8'h81, 1'b1, 8, 32, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 88, -1);
    send_frame(8'h7E, 1'b0, 32, 32, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 320, 1);
    idle(6);

    chk("scoreboard_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
